// File: rtl/pe_sequencer_pkg.sv
// Shared types and constants for the per-PE sequencer: state encoding, vector widths,
// counter widths and the packed PE state bundle seen by the buffers.
package pe_sequencer_pkg;

    localparam int unsigned I     = 4;
    localparam int unsigned F     = 4;
    localparam int unsigned MAX_C = 16;
    localparam int unsigned MAX_K = 16;
    localparam int unsigned MAX_L = 8;
    localparam int unsigned NNZ_W = 8;

    localparam int unsigned LAYER_W = $clog2(MAX_L);
    localparam int unsigned C_W     = $clog2(MAX_C);
    localparam int unsigned K_W     = $clog2(MAX_K);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StLoad    = 2'd1,
        StCompute = 2'd2,
        StPpu     = 2'd3
    } pe_state_e;

    typedef struct packed {
        pe_state_e          state;
        logic [LAYER_W-1:0] cur_layer;
        logic [C_W-1:0]     cur_c;
        logic [K_W-1:0]     cur_k;
        logic [NNZ_W-1:0]   cur_a;
        logic [NNZ_W-1:0]   cur_w;
        logic [NNZ_W-1:0]   remain_a;
        logic [NNZ_W-1:0]   remain_w;
        logic               flag_remain_a;
        logic               flag_remain_w;
    } pe_state_t;

    // Channel and k-group counts share a width; a zero count still means one pass.
    function automatic logic [C_W:0] clamp_one(input logic [C_W:0] n);
        return (n == '0) ? (C_W+1)'(1) : n;
    endfunction

endpackage

// File: rtl/pe_vec_walker.sv
// Nested activation/weight offset walker for one input channel: weight-outer,
// activation-inner, frozen by multiplier backpressure.
module pe_vec_walker
    import pe_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             stall,
    input  logic [NNZ_W-1:0] nnz_a,
    input  logic [NNZ_W-1:0] nnz_w,
    output logic [NNZ_W-1:0] cur_a,
    output logic [NNZ_W-1:0] cur_w,
    output logic             issue,
    output logic             chan_done
);

    logic [NNZ_W-1:0] a_q, w_q;
    logic skip, last_a, last_w, step, end_chan;

    // One extra bit so offset + vector width cannot wrap near the top of the range.
    assign last_a   = ({1'b0, a_q} + (NNZ_W+1)'(I)) >= {1'b0, nnz_a};
    assign last_w   = ({1'b0, w_q} + (NNZ_W+1)'(F)) >= {1'b0, nnz_w};
    assign skip     = (nnz_a == '0) || (nnz_w == '0);
    assign end_chan = skip || (last_a && last_w);
    // A skip cycle issues nothing, so backpressure does not hold it.
    assign step     = en && (skip || !stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            w_q <= '0;
        end else if (step) begin
            if (end_chan) begin
                a_q <= '0;
                w_q <= '0;
            end else if (last_a) begin
                a_q <= '0;
                w_q <= w_q + NNZ_W'(F);
            end else begin
                a_q <= a_q + NNZ_W'(I);
            end
        end
    end

    assign cur_a     = a_q;
    assign cur_w     = w_q;
    assign issue     = en && !skip;
    assign chan_done = step && end_chan;

endmodule

// File: rtl/pe_sequencer.sv
// Per-PE run sequencer: DRAM load, then per layer / k group / channel vector walks
// with PPU writeback; layer parity selects the ping-pong buffer half.
module pe_sequencer
    import pe_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LAYER_W:0]   cfg_num_layers,
    input  logic [C_W:0]       cfg_num_c,
    input  logic [K_W:0]       cfg_num_k,
    input  logic               load_done,
    input  logic               ppu_done,
    input  logic               mul_stall,
    input  logic [NNZ_W-1:0]   nnz_a,
    input  logic [NNZ_W-1:0]   nnz_w,
    output logic [1:0]         state,
    output logic [LAYER_W-1:0] cur_layer,
    output logic [C_W-1:0]     cur_c,
    output logic [K_W-1:0]     cur_k,
    output logic [NNZ_W-1:0]   cur_a,
    output logic [NNZ_W-1:0]   cur_w,
    output logic [NNZ_W-1:0]   remain_a,
    output logic [NNZ_W-1:0]   remain_w,
    output logic               flag_remain_a,
    output logic               flag_remain_w,
    output logic               mul_valid,
    output logic               busy,
    output logic               done
);

    pe_state_e          st_q;
    logic [LAYER_W-1:0] layer_q;
    logic [C_W-1:0]     c_q;
    logic [K_W-1:0]     k_q;
    logic [LAYER_W:0]   num_layers_q;
    logic [C_W:0]       num_c_q;
    logic [K_W:0]       num_k_q;
    logic               done_q;
    logic               chan_done, last_c, last_k, last_layer;

    pe_vec_walker u_walker (
        .clk       (clk),
        .rst       (rst),
        .en        (st_q == StCompute),
        .stall     (mul_stall),
        .nnz_a     (nnz_a),
        .nnz_w     (nnz_w),
        .cur_a     (cur_a),
        .cur_w     (cur_w),
        .issue     (mul_valid),
        .chan_done (chan_done)
    );

    assign last_c     = {1'b0, c_q} == (num_c_q - (C_W+1)'(1));
    assign last_k     = {1'b0, k_q} == (num_k_q - (K_W+1)'(1));
    assign last_layer = ({1'b0, layer_q} + (LAYER_W+1)'(1)) == num_layers_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q         <= StIdle;
            layer_q      <= '0;
            c_q          <= '0;
            k_q          <= '0;
            num_layers_q <= '0;
            num_c_q      <= '0;
            num_k_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (st_q)
                StIdle: begin
                    if (start) begin
                        layer_q      <= '0;
                        c_q          <= '0;
                        k_q          <= '0;
                        num_layers_q <= cfg_num_layers;
                        num_c_q      <= clamp_one(cfg_num_c);
                        num_k_q      <= clamp_one(cfg_num_k);
                        if (cfg_num_layers == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            st_q <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    if (load_done) st_q <= StCompute;
                end
                StCompute: begin
                    if (chan_done) begin
                        if (last_c) st_q <= StPpu;
                        else        c_q  <= c_q + C_W'(1);
                    end
                end
                StPpu: begin
                    if (ppu_done) begin
                        c_q <= '0;
                        if (!last_k) begin
                            k_q  <= k_q + K_W'(1);
                            st_q <= StCompute;
                        end else if (last_layer) begin
                            k_q     <= '0;
                            layer_q <= '0;
                            done_q  <= 1'b1;
                            st_q    <= StIdle;
                        end else begin
                            // Next layer reads the half just written; no reload from DRAM.
                            k_q     <= '0;
                            layer_q <= layer_q + LAYER_W'(1);
                            st_q    <= StCompute;
                        end
                    end
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    assign state         = st_q;
    assign cur_layer     = layer_q;
    assign cur_c         = c_q;
    assign cur_k         = k_q;
    assign remain_a      = nnz_a - cur_a;
    assign remain_w      = nnz_w - cur_w;
    assign flag_remain_a = remain_a >= NNZ_W'(I);
    assign flag_remain_w = remain_w >= NNZ_W'(F);
    assign busy          = st_q != StIdle;
    assign done          = done_q;

endmodule

// File: tb/tb_pe_sequencer.sv
// Scoreboard bench for pe_sequencer: expected issues are queued by the stimulus and
// popped by a negedge monitor on every accepted multiplier issue.
module tb_pe_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] cfg_num_layers = '0;
    logic [4:0] cfg_num_c = '0;
    logic [4:0] cfg_num_k = '0;
    logic       load_done = 1'b0;
    logic       ppu_done = 1'b0;
    logic       mul_stall = 1'b0;
    logic [7:0] nnz_a, nnz_w;
    logic [1:0] state;
    logic [2:0] cur_layer;
    logic [3:0] cur_c, cur_k;
    logic [7:0] cur_a, cur_w, remain_a, remain_w;
    logic       flag_remain_a, flag_remain_w, mul_valid, busy, done;

    logic [7:0] tab_a [16];
    logic [7:0] tab_w [16][16];

    assign nnz_a = tab_a[cur_c];
    assign nnz_w = tab_w[cur_k][cur_c];

    pe_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cfg_num_layers (cfg_num_layers),
        .cfg_num_c      (cfg_num_c),
        .cfg_num_k      (cfg_num_k),
        .load_done      (load_done),
        .ppu_done       (ppu_done),
        .mul_stall      (mul_stall),
        .nnz_a          (nnz_a),
        .nnz_w          (nnz_w),
        .state          (state),
        .cur_layer      (cur_layer),
        .cur_c          (cur_c),
        .cur_k          (cur_k),
        .cur_a          (cur_a),
        .cur_w          (cur_w),
        .remain_a       (remain_a),
        .remain_w       (remain_w),
        .flag_remain_a  (flag_remain_a),
        .flag_remain_w  (flag_remain_w),
        .mul_valid      (mul_valid),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int layer, k, c, w, a, ra, rw, fa, fw;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int layer, k, c, w, a, ra, rw, fa, fw);
        exp_t x;
        x.layer = layer; x.k = k; x.c = c; x.w = w; x.a = a;
        x.ra = ra; x.rw = rw; x.fa = fa; x.fw = fw;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (!rst && mul_valid && !mul_stall) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL issue_unexpected: got L%0d k%0d c%0d w%0d a%0d, required none",
                         cur_layer, cur_k, cur_c, cur_w, cur_a);
            end else begin
                e = sb.pop_front();
                if (int'(cur_layer) != e.layer || int'(cur_k) != e.k || int'(cur_c) != e.c ||
                    int'(cur_w) != e.w || int'(cur_a) != e.a || int'(remain_a) != e.ra ||
                    int'(remain_w) != e.rw || int'(flag_remain_a) != e.fa ||
                    int'(flag_remain_w) != e.fw) begin
                    failures++;
                    $display({"FAIL issue: got L%0d k%0d c%0d w%0d a%0d ra%0d rw%0d fa%0d fw%0d,",
                              " required L%0d k%0d c%0d w%0d a%0d ra%0d rw%0d fa%0d fw%0d"},
                             cur_layer, cur_k, cur_c, cur_w, cur_a, remain_a, remain_w,
                             flag_remain_a, flag_remain_w, e.layer, e.k, e.c, e.w, e.a,
                             e.ra, e.rw, e.fa, e.fw);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int s, input int limit, input string name);
        int n = 0;
        while (int'(state) != s && n < limit) begin
            tick();
            n++;
        end
        check(name, int'(state), s);
    endtask

    task automatic start_run(input int layers, input int nc, input int nk);
        cfg_num_layers = 4'(layers);
        cfg_num_c      = 5'(nc);
        cfg_num_k      = 5'(nk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_load();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic pulse_ppu();
        ppu_done = 1'b1;
        tick();
        ppu_done = 1'b0;
    endtask

    task automatic finish_ppu(input string name);
        pulse_ppu();
        check({name, "_idle"}, int'(state), 0);
        check({name, "_done"}, int'(done), 1);
        tick();
        check({name, "_done_clr"}, int'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            tab_a[i] = '0;
            for (int j = 0; j < 16; j++) tab_w[i][j] = '0;
        end
        tick();
        tick();
        rst = 1'b0;
        check("rst_state", int'(state), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(mul_valid), 0);
        check("rst_done", int'(done), 0);
        check("rst_a", int'(cur_a), 0);

        // Two activation vectors over one short weight vector.
        tab_a[0] = 8'd5; tab_w[0][0] = 8'd3;
        push(0, 0, 0, 0, 0, 5, 3, 1, 0);
        push(0, 0, 0, 0, 4, 1, 3, 0, 0);
        start_run(1, 1, 1);
        check("t1_load", int'(state), 1);
        check("t1_busy", int'(busy), 1);
        pulse_ppu();
        check("t1_ppu_ignored", int'(state), 1);
        pulse_load();
        check("t1_compute", int'(state), 2);
        wait_state(3, 10, "t1_ppu");
        check("t1_sb_empty", sb.size(), 0);
        finish_ppu("t1");

        // Full 2x2 walk with a three-cycle stall on the second issue.
        tab_a[0] = 8'd8; tab_w[0][0] = 8'd8;
        push(0, 0, 0, 0, 0, 8, 8, 1, 1);
        push(0, 0, 0, 0, 4, 4, 8, 1, 1);
        push(0, 0, 0, 4, 0, 8, 4, 1, 1);
        push(0, 0, 0, 4, 4, 4, 4, 1, 1);
        start_run(1, 1, 1);
        pulse_load();
        tick();
        mul_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_stall_a", int'(cur_a), 4);
            check("t2_stall_w", int'(cur_w), 0);
            check("t2_stall_valid", int'(mul_valid), 1);
        end
        mul_stall = 1'b0;
        wait_state(3, 10, "t2_ppu");
        check("t2_sb_empty", sb.size(), 0);
        finish_ppu("t2");

        // Empty channel 1 costs one non-issuing cycle.
        tab_a[0] = 8'd4; tab_a[1] = 8'd0; tab_a[2] = 8'd4;
        tab_w[0][0] = 8'd4; tab_w[0][1] = 8'd4; tab_w[0][2] = 8'd4;
        push(0, 0, 0, 0, 0, 4, 4, 1, 1);
        push(0, 0, 2, 0, 0, 4, 4, 1, 1);
        start_run(1, 3, 1);
        pulse_load();
        tick();
        check("t3_skip_c", int'(cur_c), 1);
        check("t3_skip_valid", int'(mul_valid), 0);
        tick();
        check("t3_c2", int'(cur_c), 2);
        check("t3_c2_valid", int'(mul_valid), 1);
        wait_state(3, 10, "t3_ppu");
        check("t3_sb_empty", sb.size(), 0);
        finish_ppu("t3");

        // Two layers of two k groups; LOAD only at the start.
        tab_a[0] = 8'd4; tab_w[0][0] = 8'd4; tab_w[1][0] = 8'd4;
        push(0, 0, 0, 0, 0, 4, 4, 1, 1);
        push(0, 1, 0, 0, 0, 4, 4, 1, 1);
        push(1, 0, 0, 0, 0, 4, 4, 1, 1);
        push(1, 1, 0, 0, 0, 4, 4, 1, 1);
        start_run(2, 1, 2);
        check("t4_load", int'(state), 1);
        pulse_load();
        for (int p = 0; p < 4; p++) begin
            check("t4_compute", int'(state), 2);
            check("t4_layer", int'(cur_layer), p / 2);
            check("t4_k", int'(cur_k), p % 2);
            wait_state(3, 10, "t4_ppu");
            if (p < 3) pulse_ppu();
        end
        check("t4_sb_empty", sb.size(), 0);
        finish_ppu("t4");

        // Reset in the middle of a channel walk.
        tab_a[0] = 8'd8; tab_w[0][0] = 8'd8;
        push(0, 0, 0, 0, 0, 8, 8, 1, 1);
        start_run(1, 1, 1);
        pulse_load();
        tick();
        check("t5_pre_rst_a", int'(cur_a), 4);
        rst = 1'b1;
        tick();
        check("t5_rst_state", int'(state), 0);
        check("t5_rst_a", int'(cur_a), 0);
        check("t5_rst_w", int'(cur_w), 0);
        check("t5_rst_valid", int'(mul_valid), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_done", int'(done), 0);
        rst = 1'b0;
        check("t5_sb_empty", sb.size(), 0);

        // Start while busy is ignored.
        tab_a[0] = 8'd4; tab_w[0][0] = 8'd4;
        push(0, 0, 0, 0, 0, 4, 4, 1, 1);
        start_run(1, 1, 1);
        start_run(0, 1, 1);
        check("t6_busy_start_state", int'(state), 1);
        check("t6_busy_start_done", int'(done), 0);
        pulse_load();
        wait_state(3, 10, "t6_ppu");
        check("t6_sb_empty", sb.size(), 0);
        finish_ppu("t6");

        // Zero layers completes immediately.
        start_run(0, 1, 1);
        check("t7_state", int'(state), 0);
        check("t7_done", int'(done), 1);
        tick();
        check("t7_done_clr", int'(done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
